// File: rtl/pwm_duty_ramp.sv
// Soft-start duty slew limiter: walks duty toward a latched target by STEP every DIV PWM periods.
// Optional build macro PWM_RAMP_LIMIT_EN clamps the latched target (and so duty) to MAX_DUTY.
module pwm_duty_ramp #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 4,
  parameter int DIV      = 2,
  parameter int MAX_DUTY = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] target,
  input  logic             target_vld,
  input  logic             period_end,
  output logic [WIDTH-1:0] duty,
  output logic             duty_load,
  output logic             busy,
  output logic             at_target
);

  // Handshake: target_vld and period_end are single-cycle strobes qualified by ena;
  // duty_load is a one-cycle strobe telling the PWM core to take duty at its next period start.

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);
  localparam logic [WIDTH:0] STEP_W   = (WIDTH + 1)'(STEP);

  if (STEP < 1 || STEP >= (2 ** WIDTH) || DIV < 1 || MAX_DUTY < 0 || MAX_DUTY >= (2 ** WIDTH))
  begin : g_bad_params
    $error("pwm_duty_ramp: illegal STEP/DIV/MAX_DUTY for WIDTH");
  end

  typedef enum logic {IDLE, RAMP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    div_cnt, div_cnt_nxt;
  logic [WIDTH-1:0] duty_q, duty_nxt, tgt_q, tgt_nxt, tgt_in, stepped;
  logic [WIDTH:0]   up_sum, down_lim;
  logic             load_q, load_nxt;

  // Target as it will be latched
  always_comb begin
`ifdef PWM_RAMP_LIMIT_EN
    tgt_in = (target > WIDTH'(MAX_DUTY)) ? WIDTH'(MAX_DUTY) : target;
`else
    tgt_in = target;
`endif
  end

  // One step toward tgt_q, computed one bit wider so neither direction can wrap
  always_comb begin
    up_sum   = {1'b0, duty_q} + STEP_W;
    down_lim = {1'b0, tgt_q} + STEP_W;
    stepped  = duty_q;
    if (duty_q < tgt_q) begin
      stepped = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[WIDTH-1:0];
    end else if (duty_q > tgt_q) begin
      stepped = ({1'b0, duty_q} < down_lim) ? tgt_q : (duty_q - STEP_W[WIDTH-1:0]);
    end
  end

  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    duty_nxt    = duty_q;
    tgt_nxt     = tgt_q;
    load_nxt    = 1'b0;
    if (ena) begin
      if (target_vld) tgt_nxt = tgt_in;
      if (state == RAMP && period_end) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          duty_nxt    = stepped;   // uses the old tgt_q even if a retarget lands now
          load_nxt    = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + CW'(1);
        end
      end
      state_nxt = (duty_nxt == tgt_nxt) ? IDLE : RAMP;
      if (state_nxt == IDLE) div_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      duty_q  <= duty_nxt;
      tgt_q   <= tgt_nxt;
      load_q  <= load_nxt;
    end
  end

  assign duty      = duty_q;
  assign duty_load = load_q;
  assign busy      = (state == RAMP);
  assign at_target = (state == IDLE);

endmodule
